// File: rtl/fma_operand_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : fma_operand_collector_if
// Description : Memory-side write bus and FMA-side drain handshake for the
//               FMA operand collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface fma_operand_collector_if #(
  parameter int WIDTH     = 16,
  parameter int FMA_COUNT = 4,
  parameter int DEPTH     = 2
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [FMA_COUNT*3*WIDTH-1:0] abc_in;
  logic [FMA_COUNT*3-1:0]       abc_valid_in;
  logic [FMA_COUNT-1:0]         lane_enable_in;
  logic                         clear_in;
  logic                         in_ready_out;
  logic [FMA_COUNT*3*WIDTH-1:0] abc_out;
  logic [FMA_COUNT-1:0]         c_valid_out;
  logic [FMA_COUNT-1:0]         lane_valid_out;
  logic                         abc_valid_out;
  logic                         abc_ready_in;
  logic [c_cnt_w-1:0]           count_out;

  // Environment side: drives writes and the drain acceptance.
  modport master (
    output abc_in, abc_valid_in, lane_enable_in, clear_in, abc_ready_in,
    input  in_ready_out, abc_out, c_valid_out, lane_valid_out, abc_valid_out, count_out
  );

  // Collector side.
  modport slave (
    input  abc_in, abc_valid_in, lane_enable_in, clear_in, abc_ready_in,
    output in_ready_out, abc_out, c_valid_out, lane_valid_out, abc_valid_out, count_out
  );
endinterface
`default_nettype wire

// File: rtl/fma_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : fma_operand_collector
// Description : Assembles scattered per-lane a/b/c writes into complete
//               operand vectors, queues up to DEPTH of them and drains them
//               to the FMA array over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fma_operand_collector #(
  parameter int WIDTH     = 16,
  parameter int FMA_COUNT = 4,
  parameter int DEPTH     = 2
) (
  input  wire logic              clk_in,
  input  wire logic              rst_n_in,
  fma_operand_collector_if.slave bus
);
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam int c_lane_w = 3 * WIDTH;

  // Slot storage: per-lane operand data and per-lane written flags.
  logic [DEPTH-1:0][FMA_COUNT-1:0][WIDTH-1:0] r_a, r_b, r_c;
  logic [DEPTH-1:0][FMA_COUNT-1:0]            r_fa, r_fb, r_fc;
  logic [c_ptr_w-1:0]                         r_head, r_tail;
  logic [c_cnt_w-1:0]                         r_count;

  logic                            w_ready;
  logic                            w_wr;
  logic                            w_valid;
  logic                            w_xfer;
  logic                            w_commit;
  logic [FMA_COUNT-1:0]            w_wa, w_wb, w_wc;
  logic [FMA_COUNT-1:0][WIDTH-1:0] w_da, w_db, w_dc;
  logic [FMA_COUNT-1:0]            w_fa_next, w_fb_next, w_fc_next, w_ab_next;

  // A fill slot exists only while the queue is not full; this depends on
  // registered count alone so ready never combinationally follows a drain.
  assign w_ready = (r_count < c_cnt_w'(DEPTH));
  // Clear discards any same-cycle writes.
  assign w_wr    = w_ready && !bus.clear_in;
  assign w_valid = (r_count != '0);
  assign w_xfer  = w_valid && bus.abc_ready_in;

  // Per-lane unpacking of write strobes/data and head-slot output packing.
  for (genvar i = 0; i < FMA_COUNT; i++) begin : g_lane
    assign w_wa[i] = w_wr && bus.abc_valid_in[3*i];
    assign w_wb[i] = w_wr && bus.abc_valid_in[3*i+1];
    assign w_wc[i] = w_wr && bus.abc_valid_in[3*i+2];
    assign w_da[i] = bus.abc_in[c_lane_w*i + 2*WIDTH +: WIDTH];
    assign w_db[i] = bus.abc_in[c_lane_w*i + WIDTH   +: WIDTH];
    assign w_dc[i] = bus.abc_in[c_lane_w*i           +: WIDTH];

    // Empty queue presents zeros; an unwritten c always reads zero.
    assign bus.abc_out[c_lane_w*i + 2*WIDTH +: WIDTH] = w_valid ? r_a[r_head][i] : '0;
    assign bus.abc_out[c_lane_w*i + WIDTH   +: WIDTH] = w_valid ? r_b[r_head][i] : '0;
    assign bus.abc_out[c_lane_w*i           +: WIDTH] =
        (w_valid && r_fc[r_head][i]) ? r_c[r_head][i] : '0;
  end

  // Flags of the fill slot as they will stand after this edge's writes.
  assign w_fa_next = r_fa[r_tail] | w_wa;
  assign w_fb_next = r_fb[r_tail] | w_wb;
  assign w_fc_next = r_fc[r_tail] | w_wc;
  assign w_ab_next = w_fa_next & w_fb_next;

  // Every enabled lane has a and b, and at least one enabled lane exists.
  assign w_commit = w_wr
                 && ((bus.lane_enable_in & ~w_ab_next) == '0)
                 && ((bus.lane_enable_in &  w_ab_next) != '0);

  assign bus.in_ready_out   = w_ready;
  assign bus.abc_valid_out  = w_valid;
  assign bus.count_out      = r_count;
  assign bus.lane_valid_out = w_valid ? (r_fa[r_head] & r_fb[r_head]) : '0;
  assign bus.c_valid_out    = w_valid ? r_fc[r_head] : '0;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_xfer)   r_head <= r_head + 1'b1;
      if (w_commit) r_tail <= r_tail + 1'b1;
      r_count <= r_count + c_cnt_w'(w_commit) - c_cnt_w'(w_xfer);
    end
  end

  // Flag update. A committed slot keeps its flags until it drains; the drain
  // clears them so the slot comes back around as an empty fill slot. Head and
  // tail never coincide while both a drain and a fill slot exist.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_fa <= '0;
      r_fb <= '0;
      r_fc <= '0;
    end else begin
      if (w_xfer) begin
        r_fa[r_head] <= '0;
        r_fb[r_head] <= '0;
        r_fc[r_head] <= '0;
      end
      if (w_ready) begin
        if (bus.clear_in) begin
          r_fa[r_tail] <= '0;
          r_fb[r_tail] <= '0;
          r_fc[r_tail] <= '0;
        end else begin
          r_fa[r_tail] <= w_fa_next;
          r_fb[r_tail] <= w_fb_next;
          r_fc[r_tail] <= w_fc_next;
        end
      end
    end
  end

  // Operand data writes into the fill slot; data needs no reset because flags gate its use.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < FMA_COUNT; i++) begin
      if (w_wa[i]) r_a[r_tail][i] <= w_da[i];
      if (w_wb[i]) r_b[r_tail][i] <= w_db[i];
      if (w_wc[i]) r_c[r_tail][i] <= w_dc[i];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fma_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fma_operand_collector
// Description : Self-checking bench for fma_operand_collector with a
//               queue-based reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_operand_collector;
  localparam int WIDTH     = 4;
  localparam int FMA_COUNT = 4;
  localparam int DEPTH     = 2;
  localparam int c_dw      = FMA_COUNT * 3 * WIDTH;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  fma_operand_collector_if #(.WIDTH(WIDTH), .FMA_COUNT(FMA_COUNT), .DEPTH(DEPTH)) bus ();

  fma_operand_collector #(.WIDTH(WIDTH), .FMA_COUNT(FMA_COUNT), .DEPTH(DEPTH)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a queue of completed vectors plus the vector being filled.
  typedef struct packed {
    logic [FMA_COUNT-1:0][WIDTH-1:0] a;
    logic [FMA_COUNT-1:0][WIDTH-1:0] b;
    logic [FMA_COUNT-1:0][WIDTH-1:0] c;
    logic [FMA_COUNT-1:0]            fa;
    logic [FMA_COUNT-1:0]            fb;
    logic [FMA_COUNT-1:0]            fc;
  } slot_t;

  slot_t q[$];
  slot_t fill;

  function automatic logic [c_dw-1:0] lane_data(input int lane, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    logic [c_dw-1:0] d;
    d = '0;
    d[3*WIDTH*lane +: 3*WIDTH] = {a, b, c};
    return d;
  endfunction

  task automatic model_reset();
    q.delete();
    fill = '0;
  endtask

  task automatic check_outputs();
    slot_t           h;
    logic [c_dw-1:0] exp_abc;
    logic [c_dw-1:0] mask;
    check_val("count", 64'(bus.count_out), 64'(q.size()));
    check_val("in_ready", 64'(bus.in_ready_out), 64'(q.size() < DEPTH));
    check_val("valid", 64'(bus.abc_valid_out), 64'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      check_val("lane_valid", 64'(bus.lane_valid_out), 64'(h.fa & h.fb));
      check_val("c_valid", 64'(bus.c_valid_out), 64'(h.fc));
      exp_abc = '0;
      mask    = '0;
      for (int i = 0; i < FMA_COUNT; i++) begin
        mask[3*WIDTH*i +: WIDTH]    = '1;
        exp_abc[3*WIDTH*i +: WIDTH] = h.fc[i] ? h.c[i] : '0;
        if (h.fa[i] && h.fb[i]) begin
          mask[3*WIDTH*i + WIDTH +: 2*WIDTH]    = '1;
          exp_abc[3*WIDTH*i + 2*WIDTH +: WIDTH] = h.a[i];
          exp_abc[3*WIDTH*i + WIDTH +: WIDTH]   = h.b[i];
        end
      end
      check_val("abc_out", 64'(bus.abc_out & mask), 64'(exp_abc));
    end
  endtask

  // One cycle: check current outputs, drive inputs, advance the model, wait for next falling edge.
  task automatic step(input logic [c_dw-1:0] d, input logic [FMA_COUNT*3-1:0] v,
                      input logic [FMA_COUNT-1:0] en, input logic clr, input logic rdy);
    slot_t                nf;
    logic [FMA_COUNT-1:0] ab;
    bit                   ready, xfer, done;
    check_outputs();
    bus.abc_in         = d;
    bus.abc_valid_in   = v;
    bus.lane_enable_in = en;
    bus.clear_in       = clr;
    bus.abc_ready_in   = rdy;
    ready = (q.size() < DEPTH);
    xfer  = (q.size() != 0) && rdy;
    done  = 1'b0;
    nf    = fill;
    if (ready) begin
      if (clr) begin
        nf = '0;
      end else begin
        for (int i = 0; i < FMA_COUNT; i++) begin
          if (v[3*i])   begin nf.a[i] = d[3*WIDTH*i + 2*WIDTH +: WIDTH]; nf.fa[i] = 1'b1; end
          if (v[3*i+1]) begin nf.b[i] = d[3*WIDTH*i + WIDTH +: WIDTH];   nf.fb[i] = 1'b1; end
          if (v[3*i+2]) begin nf.c[i] = d[3*WIDTH*i +: WIDTH];           nf.fc[i] = 1'b1; end
        end
        ab   = nf.fa & nf.fb;
        done = ((en & ~ab) == '0) && ((en & ab) != '0);
      end
    end
    if (xfer) q.delete(0);
    if (done) begin
      q.push_back(nf);
      fill = '0;
    end else begin
      fill = nf;
    end
    @(negedge clk_in);
  endtask

  initial begin
    logic [c_dw-1:0]        rd;
    logic [FMA_COUNT*3-1:0] rv;
    logic [FMA_COUNT-1:0]   ren;
    logic                   rrdy;

    bus.abc_in         = '0;
    bus.abc_valid_in   = '0;
    bus.lane_enable_in = 4'hF;
    bus.clear_in       = 1'b0;
    bus.abc_ready_in   = 1'b1;
    model_reset();
    repeat (2) @(negedge clk_in);

    // Reset values
    check_val("rst_valid", 64'(bus.abc_valid_out), 64'd0);
    check_val("rst_count", 64'(bus.count_out), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready_out), 64'd1);
    check_val("rst_abc", 64'(bus.abc_out), 64'd0);
    check_val("rst_lane_valid", 64'(bus.lane_valid_out), 64'd0);
    check_val("rst_c_valid", 64'(bus.c_valid_out), 64'd0);
    rst_n_in = 1'b1;

    // Lane 0 a/b only: no completion
    step(lane_data(0, 4'd1, 4'd2, 4'd0), 12'h003, 4'hF, 1'b0, 1'b1);
    check_val("tp_partial_valid", 64'(bus.abc_valid_out), 64'd0);
    check_val("tp_partial_count", 64'(bus.count_out), 64'd0);

    // Lanes 0..3 in successive cycles, c never written
    for (int i = 0; i < 4; i++) begin
      step(lane_data(i, 4'd1, 4'd2, 4'd0), 12'(3) << (3*i), 4'hF, 1'b0, 1'b1);
      if (i < 3) check_val("tp_fill_early", 64'(bus.abc_valid_out), 64'd0);
    end
    check_val("tp_fill_valid", 64'(bus.abc_valid_out), 64'd1);
    check_val("tp_fill_lanes", 64'(bus.lane_valid_out), 64'hF);
    check_val("tp_fill_cvalid", 64'(bus.c_valid_out), 64'h0);
    check_val("tp_fill_abc", 64'(bus.abc_out), 64'h120120120120);

    // Same again with c=9 on lane 2 only
    for (int i = 0; i < 4; i++)
      step(lane_data(i, 4'd1, 4'd2, (i == 2) ? 4'd9 : 4'd0),
           ((i == 2) ? 12'(7) : 12'(3)) << (3*i), 4'hF, 1'b0, 1'b1);
    check_val("tp_c_cvalid", 64'(bus.c_valid_out), 64'h4);
    check_val("tp_c_abc", 64'(bus.abc_out), 64'h120129120120);
    step('0, '0, 4'hF, 1'b0, 1'b1);

    // Backpressure: two full slots, third write dropped, then ordered drain
    step({4{4'd3, 4'd4, 4'd0}}, 12'h6DB, 4'hF, 1'b0, 1'b0);
    step({4{4'd7, 4'd8, 4'd0}}, 12'h6DB, 4'hF, 1'b0, 1'b0);
    check_val("tp_full_count", 64'(bus.count_out), 64'd2);
    check_val("tp_full_ready", 64'(bus.in_ready_out), 64'd0);
    step({4{4'd5, 4'd6, 4'd0}}, 12'h6DB, 4'hF, 1'b0, 1'b0);
    check_val("tp_drop_count", 64'(bus.count_out), 64'd2);
    check_val("tp_head_first", 64'(bus.abc_out), 64'h340340340340);
    step('0, '0, 4'hF, 1'b0, 1'b1);
    check_val("tp_head_second", 64'(bus.abc_out), 64'h780780780780);
    check_val("tp_drain_ready", 64'(bus.in_ready_out), 64'd1);
    step('0, '0, 4'hF, 1'b0, 1'b1);
    check_val("tp_drained", 64'(bus.abc_valid_out), 64'd0);

    // Lane mask 0011
    step(lane_data(0, 4'd2, 4'd3, 4'd0) | lane_data(1, 4'd4, 4'd5, 4'd0), 12'h01B, 4'b0011, 1'b0, 1'b0);
    check_val("tp_mask_lanes", 64'(bus.lane_valid_out), 64'h3);
    step('0, '0, 4'hF, 1'b0, 1'b1);

    // Clear beats same-cycle writes and wipes earlier partial flags
    step({4{4'd1, 4'd1, 4'd0}}, 12'h01B, 4'hF, 1'b0, 1'b1);
    step({4{4'd1, 4'd1, 4'd0}}, 12'h6C0, 4'hF, 1'b1, 1'b1);
    check_val("tp_clear_nocommit", 64'(bus.abc_valid_out), 64'd0);
    step({4{4'd1, 4'd1, 4'd0}}, 12'h6C0, 4'hF, 1'b0, 1'b1);
    check_val("tp_clear_flags", 64'(bus.abc_valid_out), 64'd0);

    // Asynchronous reset in the middle of a drain
    step({4{4'd1, 4'd1, 4'd0}}, 12'h01B, 4'hF, 1'b0, 1'b0);
    step({4{4'd2, 4'd2, 4'd0}}, 12'h6DB, 4'hF, 1'b0, 1'b0);
    step('0, '0, 4'hF, 1'b0, 1'b1);
    #2 rst_n_in = 1'b0;
    #1;
    check_val("arst_valid", 64'(bus.abc_valid_out), 64'd0);
    check_val("arst_count", 64'(bus.count_out), 64'd0);
    check_val("arst_in_ready", 64'(bus.in_ready_out), 64'd1);
    check_val("arst_abc", 64'(bus.abc_out), 64'd0);
    check_val("arst_lane_valid", 64'(bus.lane_valid_out), 64'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    model_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rd = {$urandom, $urandom};
      for (int k = 0; k < FMA_COUNT*3; k++) rv[k] = ($urandom_range(0, 9) < 4);
      ren  = ($urandom_range(0, 19) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rrdy = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      step(rd, rv, ren, ($urandom_range(0, 19) == 0), rrdy);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
